// File: rtl/seg_scan_if.sv
// Bundle between the scan driver and its surroundings: frame data in,
// decoder nibble / anode strobes / status out.
interface seg_scan_if #(
    parameter int DIGITS = 4
);
    logic [4*DIGITS-1:0] data_in;
    logic [DIGITS-1:0]   dp_in;
    logic [DIGITS-1:0]   en_in;
    logic [3:0]          hex;
    logic                blank;
    logic                dp_n;
    logic [DIGITS-1:0]   an;
    logic                frame_start;
    logic [1:0]          dbg_state;

    // No handshake: data_in/dp_in/en_in are level inputs sampled only on the
    // frame-start edge; all outputs are plain registered levels.
    modport master (
        output data_in, dp_in, en_in,
        input  hex, blank, dp_n, an, frame_start, dbg_state
    );

    modport slave (
        input  data_in, dp_in, en_in,
        output hex, blank, dp_n, an, frame_start, dbg_state
    );
endinterface

// File: rtl/seg_scan_driver.sv
// Time-multiplexed scan controller for a common-anode 7-segment display:
// frame-latched data, dead-time blanking between digits, leading-zero blanking.
module seg_scan_driver #(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 100000,
    parameter int DEAD_CYC = 16,
    parameter int LZB      = 1
) (
    input logic       clk,
    input logic       rst_n,
    seg_scan_if.slave bus
);
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int PW = $clog2(TICK_DIV);
    localparam int DW = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;
    localparam logic [IW-1:0] LAST_IDX  = IW'(DIGITS - 1);
    localparam logic [PW-1:0] LAST_PRE  = PW'(TICK_DIV - 1);
    localparam logic [DW-1:0] DEAD_LOAD = DW'(DEAD_CYC);

    typedef enum logic [1:0] {ST_WAIT, ST_DEAD, ST_DRIVE} state_t;

    state_t              state_q, state_d;
    logic [PW-1:0]       pre_q, pre_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [DW-1:0]       dead_q, dead_d;
    logic [4*DIGITS-1:0] sdata_q, sdata_d;
    logic [DIGITS-1:0]   sdp_q, sdp_d;
    logic [DIGITS-1:0]   sen_q, sen_d;
    logic [3:0]          hex_q, hex_d;
    logic [DIGITS-1:0]   an_q, an_d;
    logic                blank_q, blank_d;
    logic                dpn_q, dpn_d;
    logic                fs_q, fs_d;
    logic                tick;
    logic                drv_now;

    // A zero digit is hidden only when every enabled digit above it is zero too.
    function automatic logic visible(input logic [IW-1:0] i,
                                     input logic [4*DIGITS-1:0] d,
                                     input logic [DIGITS-1:0] e);
        logic sup;
        sup = (LZB != 0) && (i != '0) && (d[4*int'(i) +: 4] == 4'h0);
        for (int k = 0; k < DIGITS; k++) begin
            if (k > int'(i) && e[k] && d[4*k +: 4] != 4'h0) sup = 1'b0;
        end
        return e[i] && !sup;
    endfunction

    always_comb begin
        tick    = (pre_q == LAST_PRE);
        pre_d   = tick ? '0 : pre_q + 1'b1;
        state_d = state_q;
        idx_d   = idx_q;
        dead_d  = dead_q;
        sdata_d = sdata_q;
        sdp_d   = sdp_q;
        sen_d   = sen_q;
        hex_d   = hex_q;
        an_d    = an_q;
        blank_d = blank_q;
        dpn_d   = dpn_q;
        fs_d    = 1'b0;
        drv_now = 1'b0;

        if (tick) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            if (idx_d == '0) begin
                sdata_d = bus.data_in;
                sdp_d   = bus.dp_in;
                sen_d   = bus.en_in;
                fs_d    = 1'b1;
            end
            hex_d  = sdata_d[4*int'(idx_d) +: 4];
            dead_d = DEAD_LOAD;
            if (DEAD_CYC > 0) begin
                an_d    = '1;
                blank_d = 1'b1;
                dpn_d   = 1'b1;
                state_d = ST_DEAD;
            end else begin
                drv_now = 1'b1;
            end
        end else if (dead_q != '0) begin
            dead_d  = dead_q - 1'b1;
            drv_now = (dead_d == '0);
        end

        // Drive decisions read the _d copies so a fresh frame load is seen at once.
        if (drv_now) begin
            state_d = ST_DRIVE;
            if (visible(idx_d, sdata_d, sen_d)) begin
                an_d    = ~(DIGITS'(1) << idx_d);
                blank_d = 1'b0;
                dpn_d   = ~sdp_d[idx_d];
            end else begin
                an_d    = '1;
                blank_d = 1'b1;
                dpn_d   = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_WAIT;
            pre_q   <= '0;
            idx_q   <= LAST_IDX;
            dead_q  <= '0;
            sdata_q <= '0;
            sdp_q   <= '0;
            sen_q   <= '0;
            hex_q   <= 4'h0;
            an_q    <= '1;
            blank_q <= 1'b1;
            dpn_q   <= 1'b1;
            fs_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            pre_q   <= pre_d;
            idx_q   <= idx_d;
            dead_q  <= dead_d;
            sdata_q <= sdata_d;
            sdp_q   <= sdp_d;
            sen_q   <= sen_d;
            hex_q   <= hex_d;
            an_q    <= an_d;
            blank_q <= blank_d;
            dpn_q   <= dpn_d;
            fs_q    <= fs_d;
        end
    end

    assign bus.hex         = hex_q;
    assign bus.an          = an_q;
    assign bus.blank       = blank_q;
    assign bus.dp_n        = dpn_q;
    assign bus.frame_start = fs_q;
    assign bus.dbg_state   = state_q;
endmodule

// File: tb/tb_seg_scan_driver.sv
// Directed bench for seg_scan_driver: main config, an LZB=0 twin and a
// DEAD_CYC=0 twin share clock, reset and input data.
module tb_seg_scan_driver;
    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int tests_run    = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    seg_scan_if #(.DIGITS(4)) m_if ();
    seg_scan_if #(.DIGITS(4)) l_if ();
    seg_scan_if #(.DIGITS(4)) z_if ();

    seg_scan_driver #(.DIGITS(4), .TICK_DIV(8), .DEAD_CYC(2), .LZB(1)) u_main (
        .clk(clk), .rst_n(rst_n), .bus(m_if.slave));
    seg_scan_driver #(.DIGITS(4), .TICK_DIV(8), .DEAD_CYC(2), .LZB(0)) u_nolzb (
        .clk(clk), .rst_n(rst_n), .bus(l_if.slave));
    seg_scan_driver #(.DIGITS(4), .TICK_DIV(8), .DEAD_CYC(0), .LZB(1)) u_nodead (
        .clk(clk), .rst_n(rst_n), .bus(z_if.slave));

    // {an, hex, blank, dp_n, frame_start}
    logic [10:0] obs_m, obs_l, obs_z;
    assign obs_m = {m_if.an, m_if.hex, m_if.blank, m_if.dp_n, m_if.frame_start};
    assign obs_l = {l_if.an, l_if.hex, l_if.blank, l_if.dp_n, l_if.frame_start};
    assign obs_z = {z_if.an, z_if.hex, z_if.blank, z_if.dp_n, z_if.frame_start};

    function automatic logic [10:0] pk(input logic [3:0] a, input logic [3:0] h,
                                       input logic b, input logic d, input logic f);
        return {a, h, b, d, f};
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic set_inputs(input logic [15:0] d, input logic [3:0] dp, input logic [3:0] en);
        m_if.data_in = d; m_if.dp_in = dp; m_if.en_in = en;
        l_if.data_in = d; l_if.dp_in = dp; l_if.en_in = en;
        z_if.data_in = d; z_if.dp_in = dp; z_if.en_in = en;
    endtask

    task automatic wait_frame_start(input string tag);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!m_if.frame_start && n < 64);
        tests_run++;
        if (m_if.frame_start !== 1'b1) begin
            tests_failed++;
            $display("FAIL %s_frame_start_timeout: got %b want 1 within 64 cycles", tag, m_if.frame_start);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        set_inputs(16'h1234, 4'h0, 4'hF);
        step(3);
        tests_run++;
        if (obs_m !== pk(4'hF, 4'h0, 1, 1, 0)) begin
            tests_failed++;
            $display("FAIL reset_main: an/hex/blank/dp_n/fs got %b want %b", obs_m, pk(4'hF, 4'h0, 1, 1, 0));
        end
        tests_run++;
        if (obs_z !== pk(4'hF, 4'h0, 1, 1, 0)) begin
            tests_failed++;
            $display("FAIL reset_nodead: an/hex/blank/dp_n/fs got %b want %b", obs_z, pk(4'hF, 4'h0, 1, 1, 0));
        end
    endtask

    // Releases reset at a falling edge and follows the first frame of 16'h1234.
    task automatic release_scan(input string tag);
        logic [10:0] e;
        rst_n = 1'b1;
        step(7);
        e = pk(4'hF, 4'h0, 1, 1, 0);
        tests_run++;
        if (obs_m !== e) begin
            tests_failed++;
            $display("FAIL %s_pre_tick: got %b want %b", tag, obs_m, e);
        end
        step(1);
        e = pk(4'hF, 4'h4, 1, 1, 1);
        tests_run++;
        if (obs_m !== e) begin
            tests_failed++;
            $display("FAIL %s_first_tick: got %b want %b", tag, obs_m, e);
        end
        step(1);
        e = pk(4'hF, 4'h4, 1, 1, 0);
        tests_run++;
        if (obs_m !== e) begin
            tests_failed++;
            $display("FAIL %s_dead2: got %b want %b", tag, obs_m, e);
        end
        step(1);
        e = pk(4'hE, 4'h4, 0, 1, 0);
        tests_run++;
        if (obs_m !== e) begin
            tests_failed++;
            $display("FAIL %s_drive0: got %b want %b", tag, obs_m, e);
        end
        for (int k = 1; k < 4; k++) begin
            step(6);
            e = pk(4'hF, 4'(4 - k), 1, 1, 0);
            tests_run++;
            if (obs_m !== e) begin
                tests_failed++;
                $display("FAIL %s_dead_d%0d: got %b want %b", tag, k, obs_m, e);
            end
            step(2);
            e = pk(~(4'b0001 << k), 4'(4 - k), 0, 1, 0);
            tests_run++;
            if (obs_m !== e) begin
                tests_failed++;
                $display("FAIL %s_drive_d%0d: got %b want %b", tag, k, obs_m, e);
            end
        end
    endtask

    task automatic test_lzb();
        logic [10:0] e [4];
        logic [10:0] el [4];
        set_inputs(16'h0050, 4'h0, 4'hF);
        wait_frame_start("lzb");
        e[0] = pk(4'hE, 4'h0, 0, 1, 0);  el[0] = e[0];
        e[1] = pk(4'hD, 4'h5, 0, 1, 0);  el[1] = e[1];
        e[2] = pk(4'hF, 4'h0, 1, 1, 0);  el[2] = pk(4'hB, 4'h0, 0, 1, 0);
        e[3] = pk(4'hF, 4'h0, 1, 1, 0);  el[3] = pk(4'h7, 4'h0, 0, 1, 0);
        step(2);
        for (int k = 0; k < 4; k++) begin
            tests_run++;
            if (obs_m !== e[k]) begin
                tests_failed++;
                $display("FAIL lzb_main_d%0d: got %b want %b", k, obs_m, e[k]);
            end
            tests_run++;
            if (obs_l !== el[k]) begin
                tests_failed++;
                $display("FAIL lzb_off_d%0d: got %b want %b", k, obs_l, el[k]);
            end
            step(8);
        end
    endtask

    task automatic test_mid_frame();
        logic [10:0] e;
        set_inputs(16'h1234, 4'h0, 4'hF);
        wait_frame_start("midframe_load");
        step(18);
        e = pk(4'hB, 4'h2, 0, 1, 0);
        tests_run++;
        if (obs_m !== e) begin
            tests_failed++;
            $display("FAIL midframe_d2: got %b want %b", obs_m, e);
        end
        set_inputs(16'hABCD, 4'h0, 4'hF);
        step(8);
        e = pk(4'h7, 4'h1, 0, 1, 0);
        tests_run++;
        if (obs_m !== e) begin
            tests_failed++;
            $display("FAIL midframe_d3: got %b want %b", obs_m, e);
        end
        step(6);
        e = pk(4'hF, 4'hD, 1, 1, 1);
        tests_run++;
        if (obs_m !== e) begin
            tests_failed++;
            $display("FAIL midframe_newframe: got %b want %b", obs_m, e);
        end
        step(2);
        e = pk(4'hE, 4'hD, 0, 1, 0);
        tests_run++;
        if (obs_m !== e) begin
            tests_failed++;
            $display("FAIL midframe_new_d0: got %b want %b", obs_m, e);
        end
        step(8);
        e = pk(4'hD, 4'hC, 0, 1, 0);
        tests_run++;
        if (obs_m !== e) begin
            tests_failed++;
            $display("FAIL midframe_new_d1: got %b want %b", obs_m, e);
        end
    endtask

    task automatic test_en_dp();
        set_inputs(16'h1234, 4'b0001, 4'b0101);
        wait_frame_start("en_dp");
        for (int off = 0; off < 32; off++) begin
            int k;
            logic [3:0] nib;
            logic [10:0] e;
            k = off / 8;
            nib = 4'(4 - k);
            if (off % 8 < 2)  e = pk(4'hF, nib, 1, 1, off == 0);
            else if (k == 0)  e = pk(4'hE, nib, 0, 0, 0);
            else if (k == 2)  e = pk(4'hB, nib, 0, 1, 0);
            else              e = pk(4'hF, nib, 1, 1, 0);
            tests_run++;
            if (obs_m !== e) begin
                tests_failed++;
                $display("FAIL en_dp_off%0d: got %b want %b", off, obs_m, e);
            end
            step(1);
        end
    endtask

    task automatic test_async_reset();
        logic [10:0] e;
        set_inputs(16'h1234, 4'h0, 4'hF);
        wait_frame_start("async");
        step(10);
        e = pk(4'hD, 4'h3, 0, 1, 0);
        tests_run++;
        if (obs_m !== e) begin
            tests_failed++;
            $display("FAIL async_pre_d1: got %b want %b", obs_m, e);
        end
        #2 rst_n = 1'b0;
        #1;
        e = pk(4'hF, 4'h0, 1, 1, 0);
        tests_run++;
        if (obs_m !== e) begin
            tests_failed++;
            $display("FAIL async_main: got %b want %b", obs_m, e);
        end
        tests_run++;
        if (obs_z !== e) begin
            tests_failed++;
            $display("FAIL async_nodead: got %b want %b", obs_z, e);
        end
        step(3);
        release_scan("rerun");
    endtask

    task automatic test_no_dead();
        set_inputs(16'h1234, 4'h0, 4'hF);
        wait_frame_start("nodead");
        for (int off = 0; off < 32; off++) begin
            int k;
            logic [10:0] e;
            k = off / 8;
            e = pk(~(4'b0001 << k), 4'(4 - k), 0, 1, off == 0);
            tests_run++;
            if (obs_z !== e) begin
                tests_failed++;
                $display("FAIL nodead_off%0d: got %b want %b", off, obs_z, e);
            end
            step(1);
        end
    endtask

    initial begin
        test_reset();
        release_scan("scan");
        test_lzb();
        test_mid_frame();
        test_en_dp();
        test_async_reset();
        test_no_dead();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
